// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and byte-enable helper for the data-memory responder
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_RESP = 2'b10
  } stateT;

  function automatic logic [3:0] byteEnable(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return 4'b0011 << off;
      SZ_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - request/response bus between the MEM stage and the data-memory responder
interface dmem_if #(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [XLEN-1:0]      req_wdata;
  logic [1:0]           req_size;
  logic                 req_unsigned;
  logic [ADDR_SIZE-1:0] req_pc;
  logic                 resp_valid;
  logic [XLEN-1:0]      resp_rdata;
  logic                 resp_err;
  logic [ADDR_SIZE-1:0] resp_pc;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, req_pc,
    input  req_ready, resp_valid, resp_rdata, resp_err, resp_pc
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, req_pc,
    output req_ready, resp_valid, resp_rdata, resp_err, resp_pc
  );
endinterface

// File: rtl/dmem_lane_fmt.sv
// rtl/dmem_lane_fmt.sv - store lane steering and load extraction/extension (combinational)
module dmem_lane_fmt
  import dmem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      stSize,
  input  logic [1:0]      stOff,
  input  logic [XLEN-1:0] wdata,
  output logic [3:0]      wrBe,
  output logic [XLEN-1:0] wrLanes,
  input  logic [1:0]      ldSize,
  input  logic [1:0]      ldOff,
  input  logic            ldUnsigned,
  input  logic [XLEN-1:0] rawWord,
  output logic [XLEN-1:0] ldData
);

  logic [7:0]  ldByte;
  logic [15:0] ldHalf;

  assign wrBe = byteEnable(stSize, stOff);

  // Replicate the right-aligned store data into every lane; the enables pick the live ones.
  always_comb begin
    wrLanes = wdata;
    case (stSize)
      SZ_B:    wrLanes = {(XLEN/8){wdata[7:0]}};
      SZ_H:    wrLanes = {(XLEN/16){wdata[15:0]}};
      default: wrLanes = wdata;
    endcase
  end

  assign ldByte = rawWord[{ldOff, 3'b000} +: 8];
  assign ldHalf = rawWord[{ldOff[1], 4'b0000} +: 16];

  always_comb begin
    ldData = '0;
    case (ldSize)
      SZ_B:    ldData = {{(XLEN-8){ldByte[7] & ~ldUnsigned}}, ldByte};
      SZ_H:    ldData = {{(XLEN-16){ldHalf[15] & ~ldUnsigned}}, ldHalf};
      SZ_W:    ldData = rawWord;
      default: ldData = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - handshaked data memory: 1-cycle stores, 2-cycle loads, error flagging
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_SIZE   = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  stateT                state;
  logic                 respValid;
  logic                 respErr;
  logic [XLEN-1:0]      respRdata;
  logic [ADDR_SIZE-1:0] respPc;
  logic [ADDR_SIZE-1:0] pcQ;
  logic [1:0]           ldSize;
  logic [1:0]           ldOff;
  logic                 ldUnsigned;
  logic [XLEN-1:0]      rawWord;

  logic                 accept;
  logic                 reqErr;
  logic [ADDR_SIZE-3:0] wordIdx;
  logic [IDX_W-1:0]     memIdx;
  logic [3:0]           wrBe;
  logic [XLEN-1:0]      wrLanes;
  logic [XLEN-1:0]      ldData;

  assign bus.req_ready  = (state != ST_RD);
  assign bus.resp_valid = respValid;
  assign bus.resp_err   = respErr;
  assign bus.resp_rdata = respRdata;
  assign bus.resp_pc    = respPc;

  assign accept  = bus.req_valid && bus.req_ready;
  assign wordIdx = bus.req_addr[ADDR_SIZE-1:2];
  assign memIdx  = bus.req_addr[IDX_W+1:2];

  assign reqErr = (bus.req_size == 2'b11)
               || (bus.req_size == SZ_H && bus.req_addr[0])
               || (bus.req_size == SZ_W && bus.req_addr[1:0] != 2'b00)
               || (wordIdx >= (ADDR_SIZE-2)'(DEPTH_WORDS));

  dmem_lane_fmt #(.XLEN(XLEN)) u_lane_fmt (
    .stSize     (bus.req_size),
    .stOff      (bus.req_addr[1:0]),
    .wdata      (bus.req_wdata),
    .wrBe       (wrBe),
    .wrLanes    (wrLanes),
    .ldSize     (ldSize),
    .ldOff      (ldOff),
    .ldUnsigned (ldUnsigned),
    .rawWord    (rawWord),
    .ldData     (ldData)
  );

  // Array contents survive reset; only the write strobe is gated by it.
  always_ff @(posedge clk) begin
    if (reset && accept && bus.req_we && !reqErr) begin
      for (int b = 0; b < 4; b++) begin
        if (wrBe[b]) mem[memIdx][b*8 +: 8] <= wrLanes[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      respValid  <= 1'b0;
      respErr    <= 1'b0;
      respRdata  <= '0;
      respPc     <= '0;
      pcQ        <= '0;
      ldSize     <= SZ_W;
      ldOff      <= 2'b00;
      ldUnsigned <= 1'b0;
      rawWord    <= '0;
    end else begin
      respValid <= 1'b0;
      case (state)
        ST_RD: begin
          state     <= ST_RESP;
          respValid <= 1'b1;
          respErr   <= 1'b0;
          respRdata <= ldData;
          respPc    <= pcQ;
        end
        default: begin
          if (!accept) begin
            state <= ST_IDLE;
          end else if (reqErr || bus.req_we) begin
            state     <= ST_RESP;
            respValid <= 1'b1;
            respErr   <= reqErr;
            respRdata <= '0;
            respPc    <= bus.req_pc;
          end else begin
            // Formatting controls are captured here because the bus moves on during RD.
            state      <= ST_RD;
            pcQ        <= bus.req_pc;
            ldSize     <= bus.req_size;
            ldOff      <= bus.req_addr[1:0];
            ldUnsigned <= bus.req_unsigned;
            rawWord    <= mem[memIdx];
          end
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the load/store requests that the pipeline's MEM stage issues.
- Accepts requests on a valid/ready handshake and performs byte, halfword and word stores with byte enables.
- Returns loads with sign or zero extension, and flags misaligned and out-of-range accesses.
- Replaces the combinational data memory; the MEM stage stalls on req_ready low.

Parameters:
- XLEN, 32, data width in bits.
- ADDR_SIZE, 32, byte-address width.
- DEPTH_WORDS, 1024, number of XLEN-bit words in the array; must be a power of two.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_SIZE  byte address.
- req_wdata  in  XLEN  store data, right-aligned (sb uses [7:0], sh uses [15:0]).
- req_size  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_pc  in  ADDR_SIZE  pc of the requesting instruction.
- resp_valid  out  1  one-cycle response pulse; no backpressure.
- resp_rdata  out  XLEN  formatted load data; 0 for stores and errors.
- resp_err  out  1  misaligned, out-of-range or illegal size.
- resp_pc  out  ADDR_SIZE  req_pc of the request being answered.

Behaviour:
- States: IDLE, RD, RESP.
- Handshake: a request is accepted when req_valid && req_ready.
- req_ready = (state==IDLE) || (state==RESP); it is 0 in RD.
- Reset (reset==0, asynchronous):
  - state = IDLE.
  - resp_valid = 0, resp_err = 0, resp_rdata = 0, resp_pc = 0.
  - Array contents are not cleared.
  - A request in flight is dropped, with no response and no write.
- Error check, evaluated at accept:
  - req_size==11.
  - Half with addr[0]==1.
  - Word with addr[1:0]!=0.
  - Word index addr[ADDR_SIZE-1:2] >= DEPTH_WORDS.
  - On error: no array access; next state RESP with resp_err = 1 and resp_rdata = 0.
- Store accepted (no error):
  - The array is written at the accepting edge.
  - Byte enables are shifted by addr[1:0]: byte uses 1<<addr[1:0], half uses 0011<<addr[1:0], word uses 1111.
  - Data is replicated into the lanes.
  - Next state RESP: resp_valid = 1, resp_err = 0, resp_rdata = 0.
  - Store latency is 1 cycle.
- Load accepted (no error):
  - Synchronous array read is issued at the accepting edge; next state RD.
  - The RD→RESP edge registers the formatted data.
  - Byte: lane addr[1:0]. Half: lanes addr[1]*2 and addr[1]*2+1.
  - Extension follows req_unsigned, which is captured at accept together with addr[1:0] and size.
  - Load latency is 2 cycles from accept to resp_valid.
- RESP: resp_valid is high for exactly one cycle.
  - If a new request is accepted in the same cycle, go to its next state (back-to-back).
  - Otherwise go to IDLE.
  - resp_* outputs are registered and hold their values until the next response; resp_valid drops to 0.
- Read-after-write:
  - A load accepted in the RESP cycle of a store to the same word returns the new data.
  - The write completed at the earlier edge, so no bypass is required.
- resp_pc = captured req_pc for every response, including errors.
- The array uses write-first semantics only if the same-edge case is ever reached. By construction a load and a store are never accepted in the same cycle, so this case does not arise.

Decomposition:
- Package dmem_pkg holds:
  - Size encodings SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10.
  - State encodings ST_IDLE, ST_RD, ST_RESP.
  - Function for byte-enable generation.
- Sub-module dmem_lane_fmt (combinational):
  - Store side: size and addr[1:0] produce byte enables and replicated write data.
  - Load side: raw word, size, offset and unsigned produce extended data.
- Array is a behavioural register array inside dmem_responder.

Test Plan:
- Store word 0xDEADBEEF at 0x10, then load word from 0x10 → store resp_valid 1 cycle after accept with resp_err = 0; load returns 0xDEADBEEF 2 cycles after accept.
- Store byte 0x80 at 0x21, then lb from 0x21 returns 0xFFFFFF80, and lbu from 0x21 returns 0x00000080.
  - Other bytes of word 0x20 are unchanged.
- Store half 0x8001 at 0x32: lh returns 0xFFFF8001 and lhu returns 0x00008001.
  - Word 0x30 reads back as 0x8001xxxx, with the lower half preserved.
- Errors are reported with resp_pc echoed and memory unchanged:
  - lw at 0x13, sh at 0x41, req_size = 11, and word at byte address 4*DEPTH_WORDS each give resp_valid with resp_err = 1 and resp_rdata = 0.
  - Memory unchanged is verified by a subsequent read.
- Back-to-back sequence store, load, load with req_valid held high:
  - req_ready pattern is 1, 1, 0, 1, 0, 1.
  - Responses arrive in order with correct pcs.
- Assert reset low while in RD:
  - Outputs are immediately 0 and state is IDLE.
  - No resp_valid after release.
  - req_ready = 1 on the first cycle after reset release.
